// File: rtl/dlock_pkg.sv
// -----------------------------------------------------------------------------
// dlock_pkg
// Shared types and constants for the multi-digit digital lock.
//   STATE_W : width of the display-ready state code
//   state_e : lock states, encoded with the values shown on the 7-segment
//             display (0=LOCKED, 1=OPEN, 2=CHANGE, 3=LOCKOUT)
// -----------------------------------------------------------------------------
package dlock_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_LOCKED  = 4'd0,
        ST_OPEN    = 4'd1,
        ST_CHANGE  = 4'd2,
        ST_LOCKOUT = 4'd3
    } state_e;

endpackage : dlock_pkg

// File: rtl/digital_lock_multi_if.sv
// -----------------------------------------------------------------------------
// digital_lock_multi_if
// Groups the switch/button inputs and the display-facing outputs of the lock.
//   pwd         : digit value from the switches
//   btn_enter   : level, rising edge commits pwd as the next digit
//   btn_open    : level, rising edge evaluates the entered code
//   btn_close   : level, rising edge closes or aborts
//   btn_change  : level, rising edge starts or commits a code change
//   state_code  : 0=LOCKED 1=OPEN 2=CHANGE 3=LOCKOUT
//   unlocked    : high in OPEN and CHANGE
//   lockout     : high in LOCKOUT
//   digit_cnt   : digits currently buffered
//   tries_left  : failed opens remaining before lockout
// Modports: master drives the inputs (board / bench), slave is the lock core.
// -----------------------------------------------------------------------------
interface digital_lock_multi_if #(
    parameter int DIGIT_W    = 4,
    parameter int NUM_DIGITS = 4,
    parameter int MAX_TRIES  = 3
);
    import dlock_pkg::*;

    logic [DIGIT_W-1:0]                  pwd;
    logic                                btn_enter;
    logic                                btn_open;
    logic                                btn_close;
    logic                                btn_change;
    logic [STATE_W-1:0]                  state_code;
    logic                                unlocked;
    logic                                lockout;
    logic [$clog2(NUM_DIGITS+1)-1:0]     digit_cnt;
    logic [$clog2(MAX_TRIES+1)-1:0]      tries_left;

    modport master (
        output pwd, btn_enter, btn_open, btn_close, btn_change,
        input  state_code, unlocked, lockout, digit_cnt, tries_left
    );

    modport slave (
        input  pwd, btn_enter, btn_open, btn_close, btn_change,
        output state_code, unlocked, lockout, digit_cnt, tries_left
    );

endinterface : digital_lock_multi_if

// File: rtl/dlock_btn_edge.sv
// -----------------------------------------------------------------------------
// dlock_btn_edge
// One-bit rising-edge detector with a registered event output.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : level input
//   evt        : one-cycle pulse, registered, one clk after btn rises
// The history flop resets to 1 so a button held through reset release is
// treated as already seen and does not produce an event.
// -----------------------------------------------------------------------------
module dlock_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic evt
);

    logic btn_q;
    logic evt_q;
    logic evt_d;

    always_comb begin
        evt_d = btn & ~btn_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b1;
            evt_q <= 1'b0;
        end else begin
            btn_q <= btn;
            evt_q <= evt_d;
        end
    end

    assign evt = evt_q;

endmodule : dlock_btn_edge

// File: rtl/digital_lock_multi.sv
// -----------------------------------------------------------------------------
// digital_lock_multi
// Multi-digit code lock with optional failed-attempt lockout.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : digital_lock_multi_if.slave (switches, buttons, status)
// Digits are shifted into a buffer on btn_enter; btn_open compares the full
// buffer with the stored code; btn_change/btn_close manage code changes.
// Button events act two clk edges after the button rises; all outputs are
// registered. Per-cycle event priority: close > change > open > enter.
// Configuration macro: DLOCK_LOCKOUT_EN
//   defined   : failed opens count down tries_left; reaching 0 enters LOCKOUT
//               for LOCKOUT_CYCLES cycles, ignoring all buttons.
//   undefined : no LOCKOUT state or timer; tries_left is constant MAX_TRIES.
// -----------------------------------------------------------------------------
module digital_lock_multi
    import dlock_pkg::*;
#(
    parameter int                             DIGIT_W        = 4,
    parameter int                             NUM_DIGITS     = 4,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]  RESET_CODE     = '0,
    parameter int                             MAX_TRIES      = 3,
    parameter int                             LOCKOUT_CYCLES = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digital_lock_multi_if.slave   bus
);

    localparam int CODE_W = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W  = $clog2(NUM_DIGITS + 1);
    localparam int TRY_W  = $clog2(MAX_TRIES + 1);

    logic ev_enter, ev_open, ev_close, ev_change;

    dlock_btn_edge u_edge_enter  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_enter),  .evt(ev_enter));
    dlock_btn_edge u_edge_open   (.clk(clk), .rst_n(rst_n), .btn(bus.btn_open),   .evt(ev_open));
    dlock_btn_edge u_edge_close  (.clk(clk), .rst_n(rst_n), .btn(bus.btn_close),  .evt(ev_close));
    dlock_btn_edge u_edge_change (.clk(clk), .rst_n(rst_n), .btn(bus.btn_change), .evt(ev_change));

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q,  code_d;
    logic [CODE_W-1:0]   buf_q,   buf_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic                unlocked_q;
    logic                full;
    logic                clear_buf;
    logic [CODE_W-1:0]   shifted;

`ifdef DLOCK_LOCKOUT_EN
    localparam int TIMER_W = $clog2(LOCKOUT_CYCLES + 1);

    logic [TRY_W-1:0]    tries_q, tries_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic                lockout_q;
`endif

    assign full    = (cnt_q == CNT_W'(NUM_DIGITS));
    assign shifted = (buf_q << DIGIT_W) | CODE_W'(bus.pwd);

    // NOTE: every variable driven here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        clear_buf = 1'b0;
`ifdef DLOCK_LOCKOUT_EN
        tries_d   = tries_q;
        timer_d   = timer_q;
`endif

        case (state_q)
            ST_LOCKED: begin
                if (ev_close) begin
                    clear_buf = 1'b1;
                end else if (ev_change) begin
                    // change has no meaning while locked; event is consumed
                    clear_buf = 1'b0;
                end else if (ev_open) begin
                    clear_buf = 1'b1;
                    if (full && (buf_q == code_q)) begin
                        state_d = ST_OPEN;
`ifdef DLOCK_LOCKOUT_EN
                        tries_d = TRY_W'(MAX_TRIES);
`endif
                    end else begin
`ifdef DLOCK_LOCKOUT_EN
                        if (tries_q <= TRY_W'(1)) begin
                            tries_d = '0;
                            timer_d = TIMER_W'(LOCKOUT_CYCLES - 1);
                            state_d = ST_LOCKOUT;
                        end else begin
                            tries_d = tries_q - TRY_W'(1);
                        end
`endif
                    end
                end else if (ev_enter && !full) begin
                    buf_d = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_OPEN: begin
                if (ev_close) begin
                    state_d   = ST_LOCKED;
                    clear_buf = 1'b1;
                end else if (ev_change) begin
                    state_d   = ST_CHANGE;
                    clear_buf = 1'b1;
                end
            end

            ST_CHANGE: begin
                if (ev_close) begin
                    state_d   = ST_OPEN;
                    clear_buf = 1'b1;
                end else if (ev_change) begin
                    // a short code is not committed; keep collecting digits
                    if (full) begin
                        code_d    = buf_q;
                        state_d   = ST_OPEN;
                        clear_buf = 1'b1;
                    end
                end else if (ev_open) begin
                    // open outranks enter, so a simultaneous enter is dropped
                    clear_buf = 1'b0;
                end else if (ev_enter && !full) begin
                    buf_d = shifted;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef DLOCK_LOCKOUT_EN
            ST_LOCKOUT: begin
                // timer loads N-1 on entry, so the state lasts exactly N cycles
                if (timer_q == '0) begin
                    state_d   = ST_LOCKED;
                    tries_d   = TRY_W'(MAX_TRIES);
                    clear_buf = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
`endif

            default: begin
                state_d   = ST_LOCKED;
                clear_buf = 1'b1;
            end
        endcase

        if (clear_buf) begin
            buf_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOCKED;
            code_q     <= RESET_CODE;
            buf_q      <= '0;
            cnt_q      <= '0;
            unlocked_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            unlocked_q <= (state_d == ST_OPEN) || (state_d == ST_CHANGE);
        end
    end

`ifdef DLOCK_LOCKOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tries_q   <= TRY_W'(MAX_TRIES);
            timer_q   <= '0;
            lockout_q <= 1'b0;
        end else begin
            tries_q   <= tries_d;
            timer_q   <= timer_d;
            lockout_q <= (state_d == ST_LOCKOUT);
        end
    end

    assign bus.tries_left = tries_q;
    assign bus.lockout    = lockout_q;
`else
    assign bus.tries_left = TRY_W'(MAX_TRIES);
    assign bus.lockout    = 1'b0;
`endif

    assign bus.state_code = state_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.digit_cnt  = cnt_q;

endmodule : digital_lock_multi

// File: tb/tb_digital_lock_multi.sv
// -----------------------------------------------------------------------------
// tb_digital_lock_multi
// Directed bench for digital_lock_multi with DIGIT_W=4, NUM_DIGITS=4,
// RESET_CODE=16'h1234, MAX_TRIES=3, LOCKOUT_CYCLES=8. Inputs are driven and
// outputs sampled on the falling clock edge. Expectations follow the
// DLOCK_LOCKOUT_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_digital_lock_multi;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    digital_lock_multi_if #(.DIGIT_W(4), .NUM_DIGITS(4), .MAX_TRIES(3)) bus ();

    digital_lock_multi #(
        .DIGIT_W        (4),
        .NUM_DIGITS     (4),
        .RESET_CODE     (16'h1234),
        .MAX_TRIES      (3),
        .LOCKOUT_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DLOCK_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    // tries_left after a given number of consecutive failures
    function automatic logic [1:0] exp_tries(input int fails);
        if (LOCK_EN) return 2'(3 - fails);
        return 2'd3;
    endfunction

    // Raise a button set on a falling edge, drop it one cycle later, and
    // return on the falling edge after the FSM has acted.
    task automatic press(input logic en, input logic op, input logic cl, input logic ch);
        bus.btn_enter  = en;
        bus.btn_open   = op;
        bus.btn_close  = cl;
        bus.btn_change = ch;
        @(negedge clk);
        bus.btn_enter  = 1'b0;
        bus.btn_open   = 1'b0;
        bus.btn_close  = 1'b0;
        bus.btn_change = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter_digit(input logic [3:0] d);
        bus.pwd = d;
        press(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enter_code(input logic [15:0] code);
        for (int i = 3; i >= 0; i--) enter_digit(code[i*4 +: 4]);
    endtask

    task automatic test_reset;
        bus.pwd = '0; bus.btn_enter = 0; bus.btn_open = 0; bus.btn_close = 0; bus.btn_change = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vec_cnt++;
        if (bus.state_code !== 4'd0 || bus.unlocked !== 1'b0 || bus.lockout !== 1'b0) begin
            $display("FAIL reset_state: got state=%0d unl=%0b lko=%0b, want 0/0/0",
                     bus.state_code, bus.unlocked, bus.lockout);
            err_cnt++;
        end
        vec_cnt++;
        if (bus.digit_cnt !== 3'd0 || bus.tries_left !== 2'd3) begin
            $display("FAIL reset_counts: got cnt=%0d tries=%0d, want 0/3", bus.digit_cnt, bus.tries_left);
            err_cnt++;
        end
    endtask

    task automatic test_open_close;
        enter_code(16'h1234);
        vec_cnt++;
        if (bus.digit_cnt !== 3'd4) begin
            $display("FAIL digits_buffered: got %0d, want 4", bus.digit_cnt);
            err_cnt++;
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vec_cnt++;
        if (bus.state_code !== 4'd1 || bus.unlocked !== 1'b1 || bus.tries_left !== 2'd3) begin
            $display("FAIL open_ok: got state=%0d unl=%0b tries=%0d, want 1/1/3",
                     bus.state_code, bus.unlocked, bus.tries_left);
            err_cnt++;
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        vec_cnt++;
        if (bus.state_code !== 4'd0 || bus.unlocked !== 1'b0) begin
            $display("FAIL close: got state=%0d unl=%0b, want 0/0", bus.state_code, bus.unlocked);
            err_cnt++;
        end
    endtask

    task automatic test_short_and_overflow;
        enter_digit(4'd1); enter_digit(4'd2); enter_digit(4'd3);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vec_cnt++;
        if (bus.state_code !== 4'd0 || bus.tries_left !== exp_tries(1) || bus.digit_cnt !== 3'd0) begin
            $display("FAIL short_open: got state=%0d tries=%0d cnt=%0d, want 0/%0d/0",
                     bus.state_code, bus.tries_left, bus.digit_cnt, exp_tries(1));
            err_cnt++;
        end
        enter_code(16'h1234);
        enter_digit(4'd9);
        vec_cnt++;
        if (bus.digit_cnt !== 3'd4) begin
            $display("FAIL overflow_cnt: got %0d, want 4", bus.digit_cnt);
            err_cnt++;
        end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vec_cnt++;
        if (bus.state_code !== 4'd1 || bus.tries_left !== 2'd3) begin
            $display("FAIL overflow_open: got state=%0d tries=%0d, want 1/3", bus.state_code, bus.tries_left);
            err_cnt++;
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_lockout;
        for (int k = 1; k <= 3; k++) begin
            enter_code(16'h0000);
            press(1'b0, 1'b1, 1'b0, 1'b0);
        end
        vec_cnt++;
        if (bus.state_code !== (LOCK_EN ? 4'd3 : 4'd0) || bus.lockout !== LOCK_EN ||
            bus.tries_left !== exp_tries(3)) begin
            $display("FAIL lockout_enter: got state=%0d lko=%0b tries=%0d, want %0d/%0b/%0d",
                     bus.state_code, bus.lockout, bus.tries_left,
                     LOCK_EN ? 3 : 0, LOCK_EN, exp_tries(3));
            err_cnt++;
        end
        // lockout entered on edge E0; these presses span E1..E4
        enter_digit(4'd1);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vec_cnt++;
        if (LOCK_EN && (bus.state_code !== 4'd3 || bus.digit_cnt !== 3'd0)) begin
            $display("FAIL lockout_ignore: got state=%0d cnt=%0d, want 3/0", bus.state_code, bus.digit_cnt);
            err_cnt++;
        end else if (!LOCK_EN && (bus.state_code !== 4'd0 || bus.digit_cnt !== 3'd0)) begin
            $display("FAIL nolock_fail_clear: got state=%0d cnt=%0d, want 0/0", bus.state_code, bus.digit_cnt);
            err_cnt++;
        end
        repeat (3) @(negedge clk);  // after E7: last lockout cycle
        vec_cnt++;
        if (bus.lockout !== LOCK_EN) begin
            $display("FAIL lockout_hold_7: got lko=%0b, want %0b", bus.lockout, LOCK_EN);
            err_cnt++;
        end
        @(negedge clk);              // after E8: back to LOCKED
        vec_cnt++;
        if (bus.state_code !== 4'd0 || bus.lockout !== 1'b0 || bus.tries_left !== 2'd3) begin
            $display("FAIL lockout_exit: got state=%0d lko=%0b tries=%0d, want 0/0/3",
                     bus.state_code, bus.lockout, bus.tries_left);
            err_cnt++;
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_change_code;
        enter_code(16'h1234);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        vec_cnt++;
        if (bus.state_code !== 4'd2 || bus.unlocked !== 1'b1) begin
            $display("FAIL change_enter: got state=%0d unl=%0b, want 2/1", bus.state_code, bus.unlocked);
            err_cnt++;
        end
        enter_digit(4'd9); enter_digit(4'd8); enter_digit(4'd7);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        vec_cnt++;
        if (bus.state_code !== 4'd2 || bus.digit_cnt !== 3'd3) begin
            $display("FAIL change_short: got state=%0d cnt=%0d, want 2/3", bus.state_code, bus.digit_cnt);
            err_cnt++;
        end
        enter_digit(4'd6);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        vec_cnt++;
        if (bus.state_code !== 4'd1) begin
            $display("FAIL change_commit: got state=%0d, want 1", bus.state_code);
            err_cnt++;
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
        enter_code(16'h1234);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vec_cnt++;
        if (bus.state_code !== 4'd0 || bus.tries_left !== exp_tries(1)) begin
            $display("FAIL old_code_rejected: got state=%0d tries=%0d, want 0/%0d",
                     bus.state_code, bus.tries_left, exp_tries(1));
            err_cnt++;
        end
        enter_code(16'h9876);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vec_cnt++;
        if (bus.state_code !== 4'd1 || bus.tries_left !== 2'd3) begin
            $display("FAIL new_code_open: got state=%0d tries=%0d, want 1/3", bus.state_code, bus.tries_left);
            err_cnt++;
        end
        press(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_simultaneous;
        enter_code(16'h9876);
        press(1'b0, 1'b1, 1'b1, 1'b0);
        vec_cnt++;
        if (bus.state_code !== 4'd0 || bus.digit_cnt !== 3'd0 || bus.tries_left !== 2'd3) begin
            $display("FAIL close_beats_open: got state=%0d cnt=%0d tries=%0d, want 0/0/3",
                     bus.state_code, bus.digit_cnt, bus.tries_left);
            err_cnt++;
        end
        // buffer is empty now, so a lone open must fail
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vec_cnt++;
        if (bus.state_code !== 4'd0 || bus.tries_left !== exp_tries(1)) begin
            $display("FAIL cleared_open: got state=%0d tries=%0d, want 0/%0d",
                     bus.state_code, bus.tries_left, exp_tries(1));
            err_cnt++;
        end
    endtask

    task automatic test_reset_in_lockout;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vec_cnt++;
        if (bus.lockout !== LOCK_EN) begin
            $display("FAIL relock: got lko=%0b, want %0b", bus.lockout, LOCK_EN);
            err_cnt++;
        end
        bus.pwd = 4'd5;
        bus.btn_enter = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if (bus.state_code !== 4'd0 || bus.lockout !== 1'b0 || bus.tries_left !== 2'd3) begin
            $display("FAIL async_reset: got state=%0d lko=%0b tries=%0d, want 0/0/3",
                     bus.state_code, bus.lockout, bus.tries_left);
            err_cnt++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        vec_cnt++;
        if (bus.digit_cnt !== 3'd0 || bus.state_code !== 4'd0) begin
            $display("FAIL held_enter: got cnt=%0d state=%0d, want 0/0", bus.digit_cnt, bus.state_code);
            err_cnt++;
        end
        bus.btn_enter = 1'b0;
        @(negedge clk);
        enter_code(16'h1234);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        vec_cnt++;
        if (bus.state_code !== 4'd1) begin
            $display("FAIL reset_code_restored: got state=%0d, want 1", bus.state_code);
            err_cnt++;
        end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b1;
        @(negedge clk);
        test_reset();
        test_open_close();
        test_short_and_overflow();
        test_lockout();
        test_change_code();
        test_simultaneous();
        test_reset_in_lockout();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench did not complete");
    end

endmodule : tb_digital_lock_multi

// File: doc/digital_lock_multi.md
Name: digital_lock_multi

Overview:
Parametrised successor to the single-nibble digital lock core. The password is a multi-digit code entered one digit at a time from switches, committed by button. The block adds failed-attempt counting with a timed lockout and exposes a display-ready state code. It sits between the board button/switch inputs and the seven-segment controller in the FPGA top.

Parameters:
DIGIT_W, 4, bits per digit
NUM_DIGITS, 4, digits per code (>=1)
RESET_CODE, 16'h0000, code loaded at reset; width NUM_DIGITS*DIGIT_W
MAX_TRIES, 3, failed opens before lockout (>=1)
LOCKOUT_CYCLES, 100_000_000, lockout duration in clk cycles (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pwd  in  DIGIT_W  digit value from switches
btn_enter  in  1  level; rising edge commits pwd as next digit
btn_open  in  1  level; rising edge evaluates entered code
btn_close  in  1  level; rising edge closes or aborts
btn_change  in  1  level; rising edge starts or commits a code change
state_code  out  4  0=LOCKED, 1=OPEN, 2=CHANGE, 3=LOCKOUT
unlocked  out  1  high in OPEN and CHANGE
lockout  out  1  high in LOCKOUT
digit_cnt  out  $clog2(NUM_DIGITS+1)  digits currently buffered
tries_left  out  $clog2(MAX_TRIES+1)  MAX_TRIES minus failed attempts

Behaviour:
- Reset is asynchronous and active-low.
  - State = LOCKED; code = RESET_CODE; buffer = 0; digit_cnt = 0; tries_left = MAX_TRIES; lockout timer = 0.
  - Edge-detect history registers reset to 1, so a button held through reset release does not fire.
- Edge detect: event = btn & ~btn_q. Events are registered, so state and outputs change 2 clk edges after a button rises. All outputs are registered.
- Event priority per cycle: close > change > open > enter. Only the highest-priority event acts; the others are dropped.
- Digit entry (LOCKED, CHANGE):
  - enter shifts the buffer left by DIGIT_W and inserts pwd at the LSBs. Digits 1,2,3,4 therefore give 16'h1234.
  - digit_cnt saturates at NUM_DIGITS. enter while full is ignored; the buffer is unchanged.
- LOCKED:
  - open with digit_cnt==NUM_DIGITS and buffer==code: go to OPEN; tries_left = MAX_TRIES.
  - Any other open: tries_left decrements. Entry to LOCKOUT on reaching 0 is covered under LOCKOUT.
  - close: clears the buffer.
  - change: ignored.
- OPEN:
  - close: go to LOCKED.
  - change: go to CHANGE.
  - open, enter: ignored.
- CHANGE:
  - change with digit_cnt==NUM_DIGITS: code = buffer; go to OPEN.
  - change with fewer digits: ignored; the buffer is kept.
  - close: abort to OPEN; code unchanged.
- LOCKOUT:
  - Entered when tries_left decrements to 0. Timer loads LOCKOUT_CYCLES-1.
  - All button events are ignored. The timer decrements once per cycle.
  - At timer==0: go to LOCKED; tries_left = MAX_TRIES. LOCKOUT therefore lasts exactly LOCKOUT_CYCLES cycles.
- Every state transition and every failed open clears the buffer and sets digit_cnt = 0.
- Reset mid-operation (including mid-lockout) returns everything to reset values immediately, including code = RESET_CODE.

Optional Feature:
Macro DLOCK_LOCKOUT_EN.
- Defined: attempt counting and LOCKOUT behave as above.
- Undefined:
  - No LOCKOUT state and no timer logic.
  - A failed open only clears the buffer.
  - tries_left is constant MAX_TRIES; lockout is tied 0.
  - state_code never equals 3.

Decomposition:
- Package dlock_pkg holds:
  - state enum typedef (LOCKED, OPEN, CHANGE, LOCKOUT) with the 4-bit display encodings above;
  - the state_code width constant.
- Sub-module dlock_btn_edge: one-bit rising-edge detector with async reset to 1. It is instantiated four times.

Test Plan:
Bench parameters: DIGIT_W=4, NUM_DIGITS=4, RESET_CODE=16'h1234, MAX_TRIES=3, LOCKOUT_CYCLES=8.
- After reset, enter 1,2,3,4 then open -> state_code=1, unlocked=1, tries_left=3; close -> state_code=0.
- Enter 1,2,3 then open -> stays LOCKED, tries_left=2, digit_cnt=0. Enter 5 digits 1,2,3,4,9 then open -> OPEN (fifth digit ignored).
- Three wrong opens (code 16'h0000) -> state_code=3, lockout=1. Buttons pressed during lockout are ignored. After exactly 8 cycles -> LOCKED, tries_left=3.
- OPEN, change, enter 9,8,7,6, change -> OPEN. Close, then 1,2,3,4 and open fails; 9,8,7,6 and open -> OPEN.
- btn_close and btn_open rise in the same cycle in LOCKED with a correct buffer -> buffer cleared, stays LOCKED.
- rst_n pulsed low during LOCKOUT with btn_enter held high -> LOCKED, code=16'h1234. No digit is captured on release.
